// File: rtl/alu_result_stage.sv
// EX-stage ALU result select, flag derivation and 2-entry skid buffer
// toward the EX/MEM boundary.
module alu_result_stage #(
  parameter int N    = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    lu_res,
  input  logic [N-1:0]    add_res,
  input  logic            add_ovf,
  input  logic [N-1:0]    b,
  input  logic [1:0]      sel,
  input  logic            ovf_en,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_res,
  output logic            out_zero,
  output logic            out_trap,
  output logic [TAGW-1:0] out_tag
);

  typedef struct packed {
    logic [N-1:0]    res;
    logic            zero;
    logic            trap;
    logic [TAGW-1:0] tag;
  } ent_t;

  ent_t in_e;
  ent_t m_q;
  ent_t s_q;
  logic m_valid;
  logic s_valid;
  logic accept;
  logic drain;
  logic [N-1:0] sel_res;

  always_comb begin
    sel_res = '0;
    unique case (1'b1)
      (sel == 2'b00): sel_res = lu_res;
      (sel == 2'b01): sel_res = add_res;
      (sel == 2'b10): sel_res = {{(N-1){1'b0}},
                                 add_res[N-1] ^ add_ovf};
      (sel == 2'b11): sel_res = b;
      default:        sel_res = '0;
    endcase
  end

  always_comb begin
    in_e      = '0;
    in_e.res  = sel_res;
    in_e.zero = (sel_res == '0);
    in_e.trap = ovf_en & add_ovf & (sel == 2'b01);
    in_e.tag  = tag_in;
  end

  // in_ready depends only on skid occupancy, never on out_ready
  assign in_ready = !s_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = m_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_valid && s_valid) begin
      if (drain) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end
    end else if (m_valid) begin
      if (drain && accept) begin
        m_q <= in_e;
      end else if (drain) begin
        m_valid <= 1'b0;
      end else if (accept) begin
        s_valid <= 1'b1;
      end
    end else if (accept) begin
      m_q     <= in_e;
      m_valid <= 1'b1;
    end
  end

  // skid data is qualified by s_valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (m_valid && !drain && accept) begin
      s_q <= in_e;
    end
  end

  assign out_valid = m_valid;
  assign out_res   = m_q.res;
  assign out_zero  = m_q.zero;
  assign out_trap  = m_q.trap;
  assign out_tag   = m_q.tag;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Hand-computed vectors cover select, flags, stall, flush and reset.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lu_res;
  logic [31:0] add_res;
  logic        add_ovf;
  logic [31:0] b;
  logic [1:0]  sel;
  logic        ovf_en;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic        out_trap;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;
  logic        mon_en = 1'b0;
  logic [31:0] got_q[$];

  alu_result_stage #(.N(32), .TAGW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lu_res    (lu_res),
    .add_res   (add_res),
    .add_ovf   (add_ovf),
    .b         (b),
    .sel       (sel),
    .ovf_en    (ovf_en),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_trap  (out_trap),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mon_en && out_valid && out_ready)
      got_q.push_back(out_res);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0]  s,
                       input logic [31:0] lu,
                       input logic [31:0] ad,
                       input logic        ov,
                       input logic [31:0] bb,
                       input logic        oe,
                       input logic [4:0]  t);
    in_valid = 1'b1;
    sel      = s;
    lu_res   = lu;
    add_res  = ad;
    add_ovf  = ov;
    b        = bb;
    ovf_en   = oe;
    tag_in   = t;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    lu_res = '0; add_res = '0; add_ovf = 1'b0; b = '0;
    sel = 2'b00; ovf_en = 1'b0; tag_in = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res",   out_res,            32'd0);
    chk("rst_zero",  {31'b0, out_zero},  32'd0);
    chk("rst_trap",  {31'b0, out_trap},  32'd0);
    chk("rst_tag",   {27'b0, out_tag},   32'd0);
    chk("rst_ready", {31'b0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // select and flag vectors, one accepted per cycle
    drive(2'b00, 32'h0000FFFF, 32'h0, 1'b0, 32'h0, 1'b0, 5'd3);
    tick();
    chk("lu_valid", {31'b0, out_valid}, 32'd1);
    chk("lu_res",   out_res,            32'h0000FFFF);
    chk("lu_zero",  {31'b0, out_zero},  32'd0);
    chk("lu_tag",   {27'b0, out_tag},   32'd3);
    chk("lu_ready", {31'b0, in_ready},  32'd1);

    drive(2'b10, 32'h0, 32'h80000000, 1'b0, 32'h0, 1'b0, 5'd4);
    tick();
    chk("slt_neg",  out_res,            32'd1);
    chk("slt_zf",   {31'b0, out_zero},  32'd0);

    drive(2'b10, 32'h0, 32'h80000000, 1'b1, 32'h0, 1'b1, 5'd5);
    tick();
    chk("slt_ovf",  out_res,            32'd0);
    chk("slt_zf1",  {31'b0, out_zero},  32'd1);
    chk("slt_trap", {31'b0, out_trap},  32'd0);

    drive(2'b01, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd6);
    tick();
    chk("add_zero", {31'b0, out_zero},  32'd1);
    chk("add_tag",  {27'b0, out_tag},   32'd6);

    drive(2'b01, 32'h0, 32'h7FFFFFF0, 1'b1, 32'h0, 1'b1, 5'd7);
    tick();
    chk("trap_on",  {31'b0, out_trap},  32'd1);
    chk("trap_res", out_res,            32'h7FFFFFF0);

    drive(2'b01, 32'h0, 32'h7FFFFFF0, 1'b1, 32'h0, 1'b0, 5'd8);
    tick();
    chk("trap_nen", {31'b0, out_trap},  32'd0);

    drive(2'b11, 32'h0, 32'h5, 1'b1, 32'h00001234, 1'b1, 5'd9);
    tick();
    chk("passb_res",  out_res,           32'h00001234);
    chk("passb_trap", {31'b0, out_trap}, 32'd0);

    in_valid = 1'b0;
    tick();
    chk("drained", {31'b0, out_valid}, 32'd0);

    // stall stream: entries 1..4, out_ready low two cycles
    mon_en = 1'b1;
    drive(2'b00, 32'd1, 32'h0, 1'b0, 32'h0, 1'b0, 5'd1);
    tick();
    chk("st1_res", out_res, 32'd1);
    out_ready = 1'b0;
    lu_res = 32'd2; tag_in = 5'd2;
    tick();
    chk("st_full_rdy", {31'b0, in_ready},  32'd0);
    chk("st_hold1",    out_res,            32'd1);
    lu_res = 32'd3; tag_in = 5'd3;
    tick();
    chk("st_hold2",    out_res,            32'd1);
    chk("st_hold_tag", {27'b0, out_tag},   32'd1);
    chk("st_full_rd2", {31'b0, in_ready},  32'd0);
    out_ready = 1'b1;
    tick();
    chk("st2_res",  out_res,           32'd2);
    chk("st2_rdy",  {31'b0, in_ready}, 32'd1);
    tick();
    chk("st3_res",  out_res,           32'd3);
    lu_res = 32'd4; tag_in = 5'd4;
    tick();
    chk("st4_res",  out_res,           32'd4);
    in_valid = 1'b0;
    tick();
    chk("st_empty", {31'b0, out_valid}, 32'd0);
    mon_en = 1'b0;
    chk("st_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size())
        chk("st_order", got_q[i], i + 1);
    end

    // flush while FULL, with a same-cycle input
    out_ready = 1'b0;
    drive(2'b00, 32'hA, 32'h0, 1'b0, 32'h0, 1'b0, 5'd10);
    tick();
    lu_res = 32'hB; tag_in = 5'd11;
    tick();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    lu_res = 32'hC; tag_in = 5'd12;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready},  32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_gone", {31'b0, out_valid}, 32'd0);
    drive(2'b00, 32'hD, 32'h0, 1'b0, 32'h0, 1'b0, 5'd13);
    tick();
    in_valid = 1'b0;
    chk("fl_next", out_res, 32'hD);
    tick();
    chk("fl_next_dn", {31'b0, out_valid}, 32'd0);

    // async reset mid-cycle while FULL
    out_ready = 1'b0;
    drive(2'b00, 32'hE, 32'h0, 1'b0, 32'h0, 1'b0, 5'd14);
    tick();
    lu_res = 32'hF;
    tick();
    in_valid = 1'b0;
    chk("ar_full", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_res",   out_res,            32'd0);
    chk("ar_ready", {31'b0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_after", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
